access_controller: RTL and testbench

Sequential access-control core for the vehicle gate. It tracks lot occupancy, sequences the arrive → identify → pass/deny flow and drives the gate actuator. It also generates the 2-bit message selector consumed directly by the 4-letter display word multiplexer. Selector codes are FULL=2'b00, STOP=2'b01, PASS=2'b10 and FAIL=2'b11.

---
 rtl/access_controller.sv | 136 +++++++++++++
 tb/tb_access_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_controller.sv
// Vehicle gate access controller: occupancy tracking, arrive/identify/pass-or-deny
// sequencing, gate actuator drive and display message selection.
module access_controller #(
  parameter int CAPACITY   = 8,
  parameter int CNT_W      = 4,
  parameter int GATE_TICKS = 50_000_000,
  parameter int FAIL_TICKS = 50_000_000,
  parameter int TIMER_W    = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_arrive,
  input  logic             id_valid,
  input  logic             id_ok,
  input  logic             car_passed,
  input  logic             car_exit,
  output logic [1:0]       porta_seletora,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ID = 2'd1,
    OPEN    = 2'd2,
    DENY    = 2'd3
  } state_e;

  localparam logic [1:0] SEL_FULL = 2'b00;
  localparam logic [1:0] SEL_STOP = 2'b01;
  localparam logic [1:0] SEL_PASS = 2'b10;
  localparam logic [1:0] SEL_FAIL = 2'b11;

  localparam logic [CNT_W-1:0]   CAP_C     = CNT_W'(CAPACITY);
  localparam logic [TIMER_W-1:0] GATE_LOAD = TIMER_W'(GATE_TICKS - 1);
  localparam logic [TIMER_W-1:0] FAIL_LOAD = TIMER_W'(FAIL_TICKS - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [1:0]         sel_q, sel_d;
  logic               gate_q, gate_d;
  logic               entry;

  // Sequencing: state and timer next-state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    entry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (car_arrive && (occ_q < CAP_C)) state_d = WAIT_ID;
      end
      WAIT_ID: begin
        // A completed identification takes priority over the vehicle leaving.
        if (id_valid) begin
          if (id_ok) begin
            state_d = OPEN;
            timer_d = GATE_LOAD;
          end else begin
            state_d = DENY;
            timer_d = FAIL_LOAD;
          end
        end else if (!car_arrive) begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (car_passed) begin
          state_d = IDLE;
          timer_d = '0;
          entry   = 1'b1;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DENY: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Occupancy: simultaneous entry and exit cancel; both directions saturate
  always_comb begin
    occ_d = occ_q;
    case ({entry, car_exit})
      2'b10:   if (occ_q < CAP_C) occ_d = occ_q + CNT_W'(1);
      2'b01:   if (occ_q != '0)   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Registered outputs derived from the next state and next occupancy
  always_comb begin
    sel_d  = SEL_STOP;
    gate_d = 1'b0;
    case (state_d)
      IDLE:    sel_d = (occ_d == CAP_C) ? SEL_FULL : SEL_STOP;
      WAIT_ID: sel_d = SEL_STOP;
      OPEN: begin
        sel_d  = SEL_PASS;
        gate_d = 1'b1;
      end
      DENY:    sel_d = SEL_FAIL;
      default: sel_d = SEL_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      occ_q   <= '0;
      sel_q   <= SEL_STOP;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
    end
  end

  assign porta_seletora = sel_q;
  assign gate_open      = gate_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_access_controller.sv
// Directed bench for access_controller with short timers and a two-spot lot.
module tb_access_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       car_arrive = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_ok = 1'b0;
  logic       car_passed = 1'b0;
  logic       car_exit = 1'b0;
  logic [1:0] porta_seletora;
  logic       gate_open;
  logic [3:0] occupancy;

  int checks = 0;
  int passed = 0;

  access_controller #(
    .CAPACITY  (2),
    .CNT_W     (4),
    .GATE_TICKS(4),
    .FAIL_TICKS(3),
    .TIMER_W   (26)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .car_arrive    (car_arrive),
    .id_valid      (id_valid),
    .id_ok         (id_ok),
    .car_passed    (car_passed),
    .car_exit      (car_exit),
    .porta_seletora(porta_seletora),
    .gate_open     (gate_open),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arrive, then an identification strobe; returns just after the edge that acts on id_valid.
  task automatic request(input logic ok);
    car_arrive = 1'b1;
    tick();
    id_valid = 1'b1;
    id_ok    = ok;
    tick();
    id_valid   = 1'b0;
    id_ok      = 1'b0;
    car_arrive = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (porta_seletora !== 2'b01) $display("FAIL reset_sel got %b want 01", porta_seletora);
    else passed++;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL reset_gate got %b want 0", gate_open);
    else passed++;
    checks++;
    if (occupancy !== 4'd0) $display("FAIL reset_occ got %0d want 0", occupancy);
    else passed++;
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_grant();
    car_arrive = 1'b1;
    tick();
    checks++;
    if (gate_open !== 1'b0) $display("FAIL grant_waitid_gate got %b want 0", gate_open);
    else passed++;
    id_valid = 1'b1;
    id_ok    = 1'b1;
    tick();
    id_valid = 1'b0;
    id_ok    = 1'b0;
    checks++;
    if (porta_seletora !== 2'b10) $display("FAIL grant_sel got %b want 10", porta_seletora);
    else passed++;
    checks++;
    if (gate_open !== 1'b1) $display("FAIL grant_gate got %b want 1", gate_open);
    else passed++;
    tick();
    car_arrive = 1'b0;
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    checks++;
    if (occupancy !== 4'd1) $display("FAIL grant_occ got %0d want 1", occupancy);
    else passed++;
    checks++;
    if (porta_seletora !== 2'b01) $display("FAIL grant_after_sel got %b want 01", porta_seletora);
    else passed++;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL grant_after_gate got %b want 0", gate_open);
    else passed++;
  endtask

  task automatic test_timeout_deny();
    request(1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gate_open !== 1'b1) $display("FAIL timeout_open_cycle%0d got %b want 1", i, gate_open);
      else passed++;
      tick();
    end
    checks++;
    if (gate_open !== 1'b0) $display("FAIL timeout_closed got %b want 0", gate_open);
    else passed++;
    checks++;
    if (occupancy !== 4'd1) $display("FAIL timeout_occ got %0d want 1", occupancy);
    else passed++;

    request(1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (porta_seletora !== 2'b11) $display("FAIL deny_cycle%0d got %b want 11", i, porta_seletora);
      else passed++;
      tick();
    end
    checks++;
    if (porta_seletora !== 2'b01) $display("FAIL deny_end got %b want 01", porta_seletora);
    else passed++;
  endtask

  task automatic test_full();
    request(1'b1);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    checks++;
    if (occupancy !== 4'd2) $display("FAIL full_occ got %0d want 2", occupancy);
    else passed++;
    checks++;
    if (porta_seletora !== 2'b00) $display("FAIL full_sel got %b want 00", porta_seletora);
    else passed++;
    car_arrive = 1'b1;
    tick();
    id_valid = 1'b1;
    id_ok    = 1'b1;
    tick();
    id_valid = 1'b0;
    id_ok    = 1'b0;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL full_gate got %b want 0", gate_open);
    else passed++;
    checks++;
    if (porta_seletora !== 2'b00) $display("FAIL full_hold_sel got %b want 00", porta_seletora);
    else passed++;
    car_arrive = 1'b0;
    car_exit   = 1'b1;
    tick();
    car_exit = 1'b0;
    checks++;
    if (occupancy !== 4'd1) $display("FAIL full_exit_occ got %0d want 1", occupancy);
    else passed++;
    checks++;
    if (porta_seletora !== 2'b01) $display("FAIL full_exit_sel got %b want 01", porta_seletora);
    else passed++;
  endtask

  task automatic test_simultaneous();
    request(1'b1);
    car_passed = 1'b1;
    car_exit   = 1'b1;
    tick();
    car_passed = 1'b0;
    checks++;
    if (occupancy !== 4'd1) $display("FAIL simul_pass_exit_occ got %0d want 1", occupancy);
    else passed++;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL simul_pass_exit_gate got %b want 0", gate_open);
    else passed++;
    tick();
    checks++;
    if (occupancy !== 4'd0) $display("FAIL simul_exit_to0 got %0d want 0", occupancy);
    else passed++;
    tick();
    car_exit = 1'b0;
    checks++;
    if (occupancy !== 4'd0) $display("FAIL simul_exit_at0 got %0d want 0", occupancy);
    else passed++;

    // Vehicle leaves while waiting: a later id_valid must not open the gate.
    car_arrive = 1'b1;
    tick();
    car_arrive = 1'b0;
    tick();
    id_valid = 1'b1;
    id_ok    = 1'b1;
    tick();
    id_valid = 1'b0;
    id_ok    = 1'b0;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL waitid_drop_gate got %b want 0", gate_open);
    else passed++;

    // id_valid coinciding with a falling car_arrive still grants.
    car_arrive = 1'b1;
    tick();
    car_arrive = 1'b0;
    id_valid   = 1'b1;
    id_ok      = 1'b1;
    tick();
    id_valid = 1'b0;
    id_ok    = 1'b0;
    checks++;
    if (gate_open !== 1'b1) $display("FAIL idvalid_priority_gate got %b want 1", gate_open);
    else passed++;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (gate_open !== 1'b0) $display("FAIL idvalid_priority_close got %b want 0", gate_open);
    else passed++;
  endtask

  task automatic test_reset_mid_open();
    request(1'b1);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    checks++;
    if (occupancy !== 4'd1) $display("FAIL rstopen_pre_occ got %0d want 1", occupancy);
    else passed++;
    request(1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL rstopen_gate got %b want 0", gate_open);
    else passed++;
    checks++;
    if (occupancy !== 4'd0) $display("FAIL rstopen_occ got %0d want 0", occupancy);
    else passed++;
    checks++;
    if (porta_seletora !== 2'b01) $display("FAIL rstopen_sel got %b want 01", porta_seletora);
    else passed++;
    #1 rst_n = 1'b1;
    tick();
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    checks++;
    if (occupancy !== 4'd0) $display("FAIL rstopen_stale_occ got %0d want 0", occupancy);
    else passed++;
    checks++;
    if (gate_open !== 1'b0) $display("FAIL rstopen_stale_gate got %b want 0", gate_open);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_grant();
    test_timeout_deny();
    test_full();
    test_simultaneous();
    test_reset_mid_open();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
